regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next pipelined core; replaces the single-write/two-read bank.
- Generalises data width, register count, read-port count and write-port count.
- Adds write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a sequential bulk-clear engine.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥2).
- NREAD, 2, number of read ports.
- NWRITE, 2, number of write ports; higher index has priority.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.
- BYPASS, 1, when 1 same-cycle writes are forwarded to reads.
- IDXW (localparam), $clog2(NREGS), index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rs_index  in  NREAD x IDXW  read indices.
- rs_data  out  NREAD x XLEN  read data.
- rs_pending  out  NREAD  read register has an outstanding producer.
- wr_valid  in  NWRITE  write enables.
- wr_index  in  NWRITE x IDXW  write indices.
- wr_data  in  NWRITE x XLEN  write data.
- issue_valid  in  1  an instruction writing issue_index was issued.
- issue_index  in  IDXW  destination of the issued instruction.
- clear_req  in  1  start bulk clear (single-cycle pulse or level).
- ready  out  1  1 = IDLE; writes and issues accepted.
- debug_registers  out  NREGS x XLEN  current register contents.

Behaviour:
- Reset (async, rst=1):
  - All registers cleared to 0.
  - All pending bits cleared to 0.
  - FSM enters IDLE; clear counter set to 0; ready=1.
- Reads are combinational (0-cycle):
  - rs_data[p] = regs[rs_index[p]].
  - If BYPASS=1 and state is IDLE, rs_data[p] instead takes wr_data of the highest-numbered k with wr_valid[k] and wr_index[k]==rs_index[p].
- Writes commit on the rising clk edge, only in IDLE:
  - Several ports targeting the same index in one cycle: highest port number wins.
  - Different indices all commit in the same cycle.
- ZERO_REG=1:
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0, with no bypass.
  - Pending bit 0 is never set.
- Scoreboard (one pending bit per register, updated on the rising edge, only in IDLE):
  - Set when issue_valid and issue_index==i.
  - Cleared when any wr_valid[k] targets i.
  - Set and clear on the same index in the same cycle: set wins, because the new producer is younger.
  - rs_pending[p] = pending[rs_index[p]].
  - With BYPASS=1, rs_pending[p] is forced to 0 when a same-cycle write to that index is present and no same-cycle issue targets it.
- FSM:
  - IDLE → CLEARING on clear_req.
  - In CLEARING, each cycle zeroes regs[cnt] and pending[cnt], then increments cnt.
  - When cnt==NREGS-1: clear that register, return to IDLE, cnt←0.
  - Total latency is NREGS cycles; ready is 0 for exactly NREGS cycles starting the cycle after the request.
  - During CLEARING: wr_valid, issue_valid and clear_req are ignored (not queued); reads return stored contents (possibly partially cleared) with no bypass.
- Reset mid-clear: immediate IDLE with everything zero.
- Index arithmetic is unsigned IDXW bits; cnt wraps at NREGS-1 with no overflow.

Decomposition:
- Shared Types package:
  - uint32_t (existing).
  - regfile_state_e {RF_IDLE, RF_CLEARING}.
  - Default XLEN/NREGS constants.
- One sub-module, regfile_bypass_mux: per-read-port combinational priority select over the NWRITE write ports. Instantiated NREAD times.
- Scoreboard and FSM stay in regfile_mp.

Test Plan:
- Reset, then write x5=0xDEADBEEF on port 0 → the next cycle rs_data for x5 reads 0xDEADBEEF; in the write cycle itself the bypass already shows 0xDEADBEEF.
- Port 0 writes x7=0x11 and port 1 writes x7=0x22 in the same cycle → x7=0x22 afterwards; same-cycle bypass read returns 0x22.
- Write x0=0xFFFFFFFF, then issue x0 → reads of x0 return 0 and rs_pending=0.
- Issue x3 → rs_pending=1 on the next cycle. Then, in one cycle, write x3 and issue x3 → pending stays 1. Then write x3 alone → pending clears.
- Fill regs with nonzero values, pulse clear_req → ready low for 32 cycles; writes attempted during the clear are dropped; all regs and pending are 0 afterwards and ready=1.
- Assert rst at clear cycle 10 → immediate IDLE, ready=1, all regs 0. Build with NREAD=3, NWRITE=1, XLEN=64 → the same checks pass.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the multi-port integer register file.
package regfile_mp_pkg;

  typedef logic [31:0] uint32_t;

  typedef enum logic {
    RF_IDLE,
    RF_CLEARING
  } regfile_state_e;

  localparam uint32_t RF_DEFAULT_XLEN  = 32;
  localparam uint32_t RF_DEFAULT_NREGS = 32;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port forwarding select: the highest-numbered matching write port wins.
module regfile_bypass_mux #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NWRITE = 2,
  parameter int unsigned IDXW   = 5
) (
  input  logic                          bypass_en_i,
  input  logic [IDXW-1:0]               rd_index_i,
  input  logic [XLEN-1:0]               stored_i,
  input  logic [NWRITE-1:0]             wr_valid_i,
  input  logic [NWRITE-1:0][IDXW-1:0]   wr_index_i,
  input  logic [NWRITE-1:0][XLEN-1:0]   wr_data_i,
  output logic [XLEN-1:0]               data_o,
  output logic                          hit_o
);

  always_comb begin
    data_o = stored_i;
    hit_o  = 1'b0;
    if (bypass_en_i) begin
      // Ascending scan so the last match, the highest port, takes effect.
      for (int unsigned k = 0; k < NWRITE; k++) begin
        if (wr_valid_i[k] && (wr_index_i[k] == rd_index_i)) begin
          data_o = wr_data_i[k];
          hit_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, pending-write scoreboard
// and a sequential bulk-clear engine.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN     = RF_DEFAULT_XLEN,
  parameter int unsigned NREGS    = RF_DEFAULT_NREGS,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned IDXW    = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREAD-1:0][IDXW-1:0]    rs_index,
  output logic [NREAD-1:0][XLEN-1:0]    rs_data,
  output logic [NREAD-1:0]              rs_pending,
  input  logic [NWRITE-1:0]             wr_valid,
  input  logic [NWRITE-1:0][IDXW-1:0]   wr_index,
  input  logic [NWRITE-1:0][XLEN-1:0]   wr_data,
  input  logic                          issue_valid,
  input  logic [IDXW-1:0]               issue_index,
  input  logic                          clear_req,
  output logic                          ready,
  output logic [NREGS-1:0][XLEN-1:0]    debug_registers
);

  regfile_state_e              state_q;
  logic [IDXW-1:0]             cnt_q;
  logic                        ready_q;
  logic [NREGS-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [NREGS-1:0]            pending_q, pending_d;
  logic                        idle;

  assign idle            = (state_q == RF_IDLE);
  assign ready           = ready_q;
  assign debug_registers = regs_q;

  // Issue is applied after the write clears so a same-cycle set wins.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (idle) begin
      for (int unsigned k = 0; k < NWRITE; k++) begin
        if (wr_valid[k]) begin
          regs_d[wr_index[k]]    = wr_data[k];
          pending_d[wr_index[k]] = 1'b0;
        end
      end
      if (issue_valid) begin
        pending_d[issue_index] = 1'b1;
      end
    end else begin
      regs_d[cnt_q]    = '0;
      pending_d[cnt_q] = 1'b0;
    end
    if (ZERO_REG != 0) begin
      regs_d[0]    = '0;
      pending_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (clear_req) begin
            state_q <= RF_CLEARING;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        RF_CLEARING: begin
          if (cnt_q == IDXW'(NREGS - 1)) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RF_IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [XLEN-1:0] mux_data;
    logic            hit;
    logic            issue_hit;

    regfile_bypass_mux #(
      .XLEN   (XLEN),
      .NWRITE (NWRITE),
      .IDXW   (IDXW)
    ) u_mux (
      .bypass_en_i (idle && (BYPASS != 0)),
      .rd_index_i  (rs_index[p]),
      .stored_i    (regs_q[rs_index[p]]),
      .wr_valid_i  (wr_valid),
      .wr_index_i  (wr_index),
      .wr_data_i   (wr_data),
      .data_o      (mux_data),
      .hit_o       (hit)
    );

    assign issue_hit     = issue_valid && (issue_index == rs_index[p]);
    assign rs_data[p]    = ((ZERO_REG != 0) && (rs_index[p] == '0)) ? '0 : mux_data;
    assign rs_pending[p] = pending_q[rs_index[p]] && !(hit && !issue_hit);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default build plus an NREAD=3/NWRITE=1/XLEN=64 build.
module tb_regfile_mp;

  localparam int K_DATA  = 0;
  localparam int K_PEND  = 1;
  localparam int K_READY = 2;
  localparam int K_DBG   = 3;

  typedef struct {
    string       tag;
    int          d;
    int          k;
    int          i;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][4:0]   a_rs_index;
  logic [1:0][31:0]  a_rs_data;
  logic [1:0]        a_rs_pending;
  logic [1:0]        a_wr_valid;
  logic [1:0][4:0]   a_wr_index;
  logic [1:0][31:0]  a_wr_data;
  logic              a_issue_valid;
  logic [4:0]        a_issue_index;
  logic              a_clear_req;
  logic              a_ready;
  logic [31:0][31:0] a_dbg;

  logic [2:0][4:0]   b_rs_index;
  logic [2:0][63:0]  b_rs_data;
  logic [2:0]        b_rs_pending;
  logic [0:0]        b_wr_valid;
  logic [0:0][4:0]   b_wr_index;
  logic [0:0][63:0]  b_wr_data;
  logic              b_issue_valid;
  logic [4:0]        b_issue_index;
  logic              b_clear_req;
  logic              b_ready;
  logic [31:0][63:0] b_dbg;

  logic [31:0] ma [32];

  regfile_mp u_dut_a (
    .clk (clk), .rst (rst),
    .rs_index (a_rs_index), .rs_data (a_rs_data), .rs_pending (a_rs_pending),
    .wr_valid (a_wr_valid), .wr_index (a_wr_index), .wr_data (a_wr_data),
    .issue_valid (a_issue_valid), .issue_index (a_issue_index),
    .clear_req (a_clear_req), .ready (a_ready), .debug_registers (a_dbg)
  );

  regfile_mp #(.XLEN(64), .NREAD(3), .NWRITE(1)) u_dut_b (
    .clk (clk), .rst (rst),
    .rs_index (b_rs_index), .rs_data (b_rs_data), .rs_pending (b_rs_pending),
    .wr_valid (b_wr_valid), .wr_index (b_wr_index), .wr_data (b_wr_data),
    .issue_valid (b_issue_valid), .issue_index (b_issue_index),
    .clear_req (b_clear_req), .ready (b_ready), .debug_registers (b_dbg)
  );

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, o, e);
    end
  endtask

  function automatic logic [63:0] obs(input int d, input int k, input int i);
    if (d == 0) begin
      case (k)
        K_DATA:  return 64'(a_rs_data[i]);
        K_PEND:  return 64'(a_rs_pending[i]);
        K_READY: return 64'(a_ready);
        default: return 64'(a_dbg[i]);
      endcase
    end else begin
      case (k)
        K_DATA:  return b_rs_data[i];
        K_PEND:  return 64'(b_rs_pending[i]);
        K_READY: return 64'(b_ready);
        default: return b_dbg[i];
      endcase
    end
  endfunction

  task automatic push(input string tag, input int d, input int k, input int i, input logic [63:0] e);
    sb.push_back('{tag, d, k, i, e});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.d, e.k, e.i), e.exp);
    end
  endtask

  task automatic cyc();
    #3;
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_wr_valid = '0; a_issue_valid = 1'b0; a_clear_req = 1'b0;
    b_wr_valid = '0; b_issue_valid = 1'b0; b_clear_req = 1'b0;
  endtask

  task automatic a_wr(input int port, input logic [4:0] idx, input logic [31:0] data);
    a_wr_valid[port] = 1'b1;
    a_wr_index[port] = idx;
    a_wr_data[port]  = data;
  endtask

  task automatic a_issue(input logic [4:0] idx);
    a_issue_valid = 1'b1;
    a_issue_index = idx;
  endtask

  task automatic push_dbg_zero(input int d, input string pre);
    for (int i = 0; i < 32; i++) push($sformatf("%s_dbg%0d", pre, i), d, K_DBG, i, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_rs_index = '0; a_wr_index = '0; a_wr_data = '0; a_issue_index = '0;
    b_rs_index = '0; b_wr_index = '0; b_wr_data = '0; b_issue_index = '0;
    idle_all();
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    push("rst_ready_a", 0, K_READY, 0, 64'd1);
    push("rst_ready_b", 1, K_READY, 0, 64'd1);
    push("rst_pend_a", 0, K_PEND, 0, 64'd0);
    push_dbg_zero(0, "rst_a");
    cyc();

    // Single write with same-cycle bypass
    a_rs_index[0] = 5'd5;
    a_wr(0, 5'd5, 32'hDEADBEEF);
    push("byp_x5", 0, K_DATA, 0, 64'hDEADBEEF);
    cyc();
    idle_all();
    push("rd_x5", 0, K_DATA, 0, 64'hDEADBEEF);
    cyc();

    // Port priority on the same index
    a_rs_index[1] = 5'd7;
    a_wr(0, 5'd7, 32'h11);
    a_wr(1, 5'd7, 32'h22);
    push("byp_x7_prio", 0, K_DATA, 1, 64'h22);
    cyc();
    idle_all();
    push("rd_x7_prio", 0, K_DATA, 1, 64'h22);
    push("dbg_x7_prio", 0, K_DBG, 7, 64'h22);
    cyc();

    // Hardwired zero register
    a_rs_index[0] = 5'd0;
    a_wr(1, 5'd0, 32'hFFFFFFFF);
    push("byp_x0", 0, K_DATA, 0, 64'd0);
    cyc();
    idle_all();
    a_issue(5'd0);
    push("rd_x0", 0, K_DATA, 0, 64'd0);
    push("pend_x0_iss", 0, K_PEND, 0, 64'd0);
    push("dbg_x0", 0, K_DBG, 0, 64'd0);
    cyc();
    idle_all();
    push("pend_x0", 0, K_PEND, 0, 64'd0);
    cyc();

    // Scoreboard set / set-wins / clear
    a_rs_index[0] = 5'd3;
    a_issue(5'd3);
    push("pend_x3_pre", 0, K_PEND, 0, 64'd0);
    cyc();
    idle_all();
    push("pend_x3_set", 0, K_PEND, 0, 64'd1);
    cyc();
    a_wr(0, 5'd3, 32'h33);
    a_issue(5'd3);
    push("pend_x3_setwin_byp", 0, K_PEND, 0, 64'd1);
    push("data_x3_byp", 0, K_DATA, 0, 64'h33);
    cyc();
    idle_all();
    push("pend_x3_setwin", 0, K_PEND, 0, 64'd1);
    push("data_x3", 0, K_DATA, 0, 64'h33);
    cyc();
    a_wr(1, 5'd3, 32'h44);
    push("pend_x3_clr_byp", 0, K_PEND, 0, 64'd0);
    push("data_x3_44_byp", 0, K_DATA, 0, 64'h44);
    cyc();
    idle_all();
    push("pend_x3_clr", 0, K_PEND, 0, 64'd0);
    push("dbg_x3", 0, K_DBG, 3, 64'h44);
    cyc();

    // Fill all registers, mark x9 pending
    ma[0] = 32'd0;
    for (int i = 1; i < 32; i += 2) begin
      idle_all();
      ma[i] = 32'hA500_0000 + 32'(i);
      a_wr(0, 5'(i), ma[i]);
      if (i + 1 < 32) begin
        ma[i+1] = 32'hA500_0000 + 32'(i + 1);
        a_wr(1, 5'(i + 1), ma[i+1]);
      end
      cyc();
    end
    idle_all();
    a_issue(5'd9);
    cyc();
    idle_all();
    a_rs_index[0] = 5'd9;
    push("pend_x9_fill", 0, K_PEND, 0, 64'd1);
    for (int i = 0; i < 32; i++) push($sformatf("fill_dbg%0d", i), 0, K_DBG, i, 64'(ma[i]));
    cyc();

    // Bulk clear; writes, issues and held clear_req must be ignored
    a_clear_req = 1'b1;
    a_rs_index[0] = 5'd2;
    a_rs_index[1] = 5'd9;
    push("ready_req", 0, K_READY, 0, 64'd1);
    cyc();
    for (int c = 0; c < 32; c++) begin
      idle_all();
      a_clear_req = (c < 5);
      a_wr(0, 5'd2, 32'hAA);
      a_wr(1, 5'd9, 32'hBB);
      a_issue(5'd20);
      push($sformatf("ready_clr%0d", c), 0, K_READY, 0, 64'd0);
      push($sformatf("data_x2_clr%0d", c), 0, K_DATA, 0, (c <= 2) ? 64'(ma[2]) : 64'd0);
      push($sformatf("pend_x9_clr%0d", c), 0, K_PEND, 1, (c <= 9) ? 64'd1 : 64'd0);
      cyc();
    end
    idle_all();
    a_rs_index[0] = 5'd20;
    push("ready_done", 0, K_READY, 0, 64'd1);
    push("pend_x20_done", 0, K_PEND, 0, 64'd0);
    push("pend_x9_done", 0, K_PEND, 1, 64'd0);
    push_dbg_zero(0, "clr");
    cyc();

    // Reset during clear cycle 10
    a_wr(0, 5'd20, 32'h1234);
    a_wr(1, 5'd30, 32'h5678);
    cyc();
    idle_all();
    a_clear_req = 1'b1;
    push("dbg_x30_preclr", 0, K_DBG, 30, 64'h5678);
    cyc();
    idle_all();
    for (int c = 0; c < 10; c++) begin
      push($sformatf("ready_pre_rst%0d", c), 0, K_READY, 0, 64'd0);
      cyc();
    end
    #1;
    rst = 1'b1;
    #1;
    push("ready_midrst", 0, K_READY, 0, 64'd1);
    push_dbg_zero(0, "midrst");
    drain();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push("ready_postrst", 0, K_READY, 0, 64'd1);
    cyc();

    // Wide build: NREAD=3, NWRITE=1, XLEN=64
    b_rs_index[2] = 5'd5;
    b_wr_valid[0] = 1'b1; b_wr_index[0] = 5'd5; b_wr_data[0] = 64'hDEADBEEF_CAFEF00D;
    push("b_byp_x5", 1, K_DATA, 2, 64'hDEADBEEF_CAFEF00D);
    cyc();
    idle_all();
    push("b_rd_x5", 1, K_DATA, 2, 64'hDEADBEEF_CAFEF00D);
    cyc();
    b_rs_index[1] = 5'd0;
    b_wr_valid[0] = 1'b1; b_wr_index[0] = 5'd0; b_wr_data[0] = '1;
    push("b_byp_x0", 1, K_DATA, 1, 64'd0);
    cyc();
    idle_all();
    b_rs_index[0] = 5'd3;
    b_issue_valid = 1'b1; b_issue_index = 5'd3;
    push("b_rd_x0", 1, K_DATA, 1, 64'd0);
    push("b_pend_x3_pre", 1, K_PEND, 0, 64'd0);
    cyc();
    idle_all();
    push("b_pend_x3", 1, K_PEND, 0, 64'd1);
    b_wr_valid[0] = 1'b1; b_wr_index[0] = 5'd31; b_wr_data[0] = 64'h0123_4567_89AB_CDEF;
    cyc();
    idle_all();
    b_clear_req = 1'b1;
    push("b_dbg_x31", 1, K_DBG, 31, 64'h0123_4567_89AB_CDEF);
    cyc();
    idle_all();
    for (int c = 0; c < 32; c++) begin
      push($sformatf("b_ready_clr%0d", c), 1, K_READY, 0, 64'd0);
      cyc();
    end
    push("b_ready_done", 1, K_READY, 0, 64'd1);
    push("b_pend_x3_done", 1, K_PEND, 0, 64'd0);
    push_dbg_zero(1, "b_clr");
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
